modport_mem: RTL and testbench
==============================

// Module: modport_mem
// PURPOSE
// - AXI4-Lite subordinate backed by a word-addressed register array: the slave-side
//   (S modport) endpoint for memory-mapped bus-interface bring-up.
// - Write and read paths are independent; one outstanding transaction per direction.
// PARAMETERS
// - ALEN   32        address width, bits
// - DLEN   32        data width, bits (multiple of 8)
// - SLEN   DLEN/8    write-strobe width, bytes per word
// - DEPTH  16        number of DLEN words (power of 2, >=2)
// PORTS
// - aclk     in   1     clock; all state changes on its rising edge
// - areset   in   1     reset, asynchronous assert, active-high
// - awvalid  in   1     write address valid
// - awready  out  1     write address ready
// - awaddr   in   ALEN  write byte address
// - awprot   in   3     protection; ignored
// - wvalid   in   1     write data valid
// - wready   out  1     write data ready
// - wdata    in   DLEN  write data
// - wstrb    in   SLEN  byte enables, bit i -> wdata[8i+7:8i]
// - bvalid   out  1     write response valid
// - bready   in   1     write response ready
// - bresp    out  2     2'b00 OKAY, 2'b10 SLVERR
// - arvalid  in   1     read address valid
// - arready  out  1     read address ready
// - araddr   in   ALEN  read byte address
// - arprot   in   3     protection; ignored
// - rvalid   out  1     read data valid
// - rready   in   1     read data ready
// - rdata    out  DLEN  read data
// - rresp    out  2     2'b00 OKAY, 2'b10 SLVERR
// BEHAVIOUR
// - Decode: OFS=$clog2(SLEN), IW=$clog2(DEPTH); index=addr[OFS+:IW]; addr[OFS-1:0] ignored;
//   any nonzero addr[ALEN-1:OFS+IW] -> out of range.
// - Reset (async, while areset=1): bvalid=rvalid=0, bresp=rresp=0, rdata=0, both
//   holding flags cleared, all DEPTH words cleared to 0.
// - Handshake occurs on a rising edge with valid&ready both high.
// - AW holding register: awready=!aw_held (combinational). AW handshake latches awaddr, sets aw_held.
// - W holding register: wready=!w_held. W handshake latches wdata/wstrb, sets w_held.
// - AW and W are accepted in either order or in the same cycle.
// - Commit: on an edge where aw_held & w_held & !bvalid:
//   - in range: write the strobed bytes of the held data into word[index]; bresp=OKAY;
//   - out of range: no write; bresp=SLVERR;
//   - in both cases set bvalid=1 and clear aw_held and w_held.
// - Write latency: AW+W accepted at edge N -> commit and bvalid=1 after edge N+1.
// - bvalid and bresp hold stable until bready; bvalid clears on the edge with bvalid&bready.
// - Read: arready=!rvalid. AR handshake at edge N registers, after edge N:
//   - rvalid=1;
//   - rdata=word[index], rresp=OKAY; or, if out of range, rdata=0, rresp=SLVERR.
// - rvalid, rdata and rresp hold until rready; rvalid clears on the edge with rvalid&rready.
//   A new AR cannot be accepted in that same cycle.
// - Same-edge write commit and AR accept to the same word: the read returns pre-write data.
// - wstrb=0 is a legal write: no bytes change, bresp=OKAY.
// - Reset asserted mid-transaction aborts it: pending AW/W/B/R are discarded and memory is zeroed.
// - valid inputs are never required to depend on ready outputs. No combinational path
//   from any input to any output except none (ready outputs depend only on state).
// TESTING
// - Reset then read addr 0x0 -> rvalid next cycle, rdata=0, rresp=OKAY.
// - AW 0x4 + W 0xDEADBEEF (wstrb=4'hF) in the same cycle -> bvalid 2 edges later, bresp=OKAY;
//   then read 0x4 -> 0xDEADBEEF.
// - W sent 3 cycles before AW (0x8, 0x11223344, wstrb=4'b0101), word previously 0xFFFFFFFF
//   -> wready=0 while waiting; read 0x8 -> 0xFF22FF44.
// - Write and read to 0x100 (DEPTH=16) -> bresp=SLVERR, rresp=SLVERR, rdata=0; no word modified.
// - Hold bready=0 for 5 cycles after a write -> bvalid and bresp stable; a second AW+W pair is
//   held but not committed until B completes. Same test on the read path with rready=0.
// - Assert areset during a pending write (AW held, W not yet sent)
//   -> all valid outputs 0, memory reads back 0.

Source files
------------

// File: rtl/modport_mem.sv
// modport_mem: AXI4-Lite subordinate backed by a DEPTH x DLEN word register array.
// Write (AW/W/B) and read (AR/R) paths are independent, one outstanding
// transaction per direction.
// Ports:
//   aclk, areset                      clock, async active-high reset
//   awvalid/awready/awaddr/awprot     write address channel (awprot ignored)
//   wvalid/wready/wdata/wstrb         write data channel
//   bvalid/bready/bresp               write response channel
//   arvalid/arready/araddr/arprot     read address channel (arprot ignored)
//   rvalid/rready/rdata/rresp         read data channel
// Ready outputs are derived only from internal state; every other output is registered.
module modport_mem #(
    parameter int unsigned ALEN  = 32,
    parameter int unsigned DLEN  = 32,
    parameter int unsigned SLEN  = DLEN / 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ALEN-1:0] awaddr,
    input  logic [2:0]      awprot,
    input  logic            wvalid,
    output logic            wready,
    input  logic [DLEN-1:0] wdata,
    input  logic [SLEN-1:0] wstrb,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    input  logic            arvalid,
    output logic            arready,
    input  logic [ALEN-1:0] araddr,
    input  logic [2:0]      arprot,
    output logic            rvalid,
    input  logic            rready,
    output logic [DLEN-1:0] rdata,
    output logic [1:0]      rresp
);

    localparam int unsigned OFS = $clog2(SLEN);
    localparam int unsigned IW  = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Any address bit above the word index makes the access out of range.
    function automatic logic addr_oor(input logic [ALEN-1:0] a);
        return (a >> (OFS + IW)) != '0;
    endfunction

    logic [DLEN-1:0] mem [DEPTH];

    logic            aw_held;
    logic [IW-1:0]   aw_idx;
    logic            aw_oor;
    logic            w_held;
    logic [DLEN-1:0] w_data;
    logic [SLEN-1:0] w_strb;

    logic            aw_hs_c;
    logic            w_hs_c;
    logic            ar_hs_c;
    logic            commit_c;
    logic [DLEN-1:0] merged_c;
    logic            unused_c;

    assign awready  = !aw_held;
    assign wready   = !w_held;
    assign arready  = !rvalid;

    assign aw_hs_c  = awvalid && awready;
    assign w_hs_c   = wvalid && wready;
    assign ar_hs_c  = arvalid && arready;
    // Commit waits for the previous response to drain so bresp never changes under bvalid.
    assign commit_c = aw_held && w_held && !bvalid;

    assign unused_c = ^{awprot, arprot};

    // Byte-merge of the held write data into the addressed word.
    always_comb begin
        merged_c = mem[aw_idx];
        for (int unsigned i = 0; i < SLEN; i++) begin
            if (w_strb[i]) begin
                merged_c[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    // Write channel holding registers and response.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held <= 1'b0;
            aw_idx  <= '0;
            aw_oor  <= 1'b0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (aw_hs_c) begin
                aw_held <= 1'b1;
                aw_idx  <= awaddr[OFS +: IW];
                aw_oor  <= addr_oor(awaddr);
            end
            if (w_hs_c) begin
                w_held <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (commit_c) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Storage array; cleared on reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem <= '{default: '0};
        end else if (commit_c && !aw_oor) begin
            mem[aw_idx] <= merged_c;
        end
    end

    // Read channel; reads the array before any same-edge commit lands.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs_c) begin
            rvalid <= 1'b1;
            if (addr_oor(araddr)) begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end else begin
                rdata <= mem[araddr[OFS +: IW]];
                rresp <= RESP_OKAY;
            end
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modport_mem.sv
// tb_modport_mem: randomized + directed bench for modport_mem against a byte-level
// memory model. Inputs are driven and outputs sampled on the falling edge of aclk.
module tb_modport_mem;

    localparam int unsigned ALEN  = 32;
    localparam int unsigned DLEN  = 32;
    localparam int unsigned SLEN  = 4;
    localparam int unsigned DEPTH = 16;

    logic            aclk;
    logic            areset;
    logic            awvalid, awready;
    logic [ALEN-1:0] awaddr;
    logic [2:0]      awprot;
    logic            wvalid, wready;
    logic [DLEN-1:0] wdata;
    logic [SLEN-1:0] wstrb;
    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic            arvalid, arready;
    logic [ALEN-1:0] araddr;
    logic [2:0]      arprot;
    logic            rvalid, rready;
    logic [DLEN-1:0] rdata;
    logic [1:0]      rresp;

    modport_mem #(.ALEN(ALEN), .DLEN(DLEN), .SLEN(SLEN), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: a flat byte-addressable memory of DEPTH*SLEN bytes.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic [31:0] model [DEPTH];
    wr_t         pend [$];

    function automatic bit is_oor(input logic [31:0] a);
        return a >= 32'(DEPTH * SLEN);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return is_oor(a) ? 32'h0 : model[a / SLEN];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return is_oor(a) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input wr_t w);
        logic [31:0] mask;
        if (is_oor(w.addr)) return;
        for (int b = 0; b < 4; b++) begin
            if (w.strb[b]) begin
                mask = 32'hFF << (8 * b);
                model[w.addr / SLEN] = (model[w.addr / SLEN] & ~mask) | (w.data & mask);
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        pend.delete();
    endtask

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Present AW and W with independent start delays; returns once both are accepted.
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        wr_t w;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            if (w_done && !aw_done) check("wready_wait", 32'(wready), 32'h0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_accept", 32'(aw_done && w_done), 32'h1);
        w.addr = addr;
        w.data = data;
        w.strb = strb;
        pend.push_back(w);
    endtask

    // Wait for the oldest outstanding response, hold bready low, then complete it.
    task automatic wait_b(input int hold, input int exp_lat);
        int n = 0;
        wr_t w;
        logic [1:0] er;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        check("b_valid", 32'(bvalid), 32'h1);
        if (exp_lat >= 0) check("b_latency", 32'(n), 32'(exp_lat));
        if (pend.size() == 0) begin
            check("b_pending", 32'h0, 32'h1);
            return;
        end
        w  = pend.pop_front();
        er = exp_resp(w.addr);
        check("bresp", 32'(bresp), 32'(er));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_hold_valid", 32'(bvalid), 32'h1);
            check("b_hold_resp", 32'(bresp), 32'(er));
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_clear", 32'(bvalid), 32'h0);
        model_write(w);
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_dly, input int w_dly, input int hold);
        send_aw_w(addr, data, strb, aw_dly, w_dly);
        wait_b(hold, 1);
    endtask

    task automatic read(input logic [31:0] addr, input int hold);
        int n = 0;
        bit got = 0, hs;
        logic [31:0] ed = model_read(addr);
        logic [1:0]  er = exp_resp(addr);
        arvalid = 1'b1;
        araddr  = addr;
        while (n < 20) begin
            hs = arready;
            tick();
            if (hs) begin
                got = 1;
                break;
            end
            n++;
        end
        arvalid = 1'b0;
        check("ar_accept", 32'(got), 32'h1);
        check("r_valid", 32'(rvalid), 32'h1);
        check("rdata", rdata, ed);
        check("rresp", 32'(rresp), 32'(er));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_hold_valid", 32'(rvalid), 32'h1);
            check("r_hold_data", rdata, ed);
            check("r_hold_arready", 32'(arready), 32'h0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_clear", 32'(rvalid), 32'h0);
    endtask

    // Commit and AR accept on the same edge to the same word: read sees old data.
    task automatic same_edge(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] old = model_read(addr);
        wr_t w;
        awvalid = 1'b1; awaddr = addr;
        wvalid  = 1'b1; wdata  = data; wstrb = 4'hF;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        w.addr = addr; w.data = data; w.strb = 4'hF;
        pend.push_back(w);
        arvalid = 1'b1;
        araddr  = addr;
        check("se_arready", 32'(arready), 32'h1);
        tick();
        arvalid = 1'b0;
        check("se_rvalid", 32'(rvalid), 32'h1);
        check("se_rdata_old", rdata, old);
        wait_b(0, 0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0)
            return (32'($urandom_range(1, 1023)) << 6) | 32'($urandom_range(0, 63));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        areset = 1'b1;
        awvalid = 0; awaddr = 0; awprot = 0;
        wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; araddr = 0; arprot = 0; rready = 0;
        model_clear();
        @(negedge aclk);
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_bresp", 32'(bresp), 32'h0);
        check("rst_rresp", 32'(rresp), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'({awready, wready, arready}), 32'h7);
        tick();
        areset = 1'b0;
        tick();

        read(32'h0, 0);

        write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        read(32'h4, 0);
        check("deadbeef", model_read(32'h4), 32'hDEADBEEF);

        write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        write(32'h8, 32'h11223344, 4'b0101, 3, 0, 0);
        read(32'h8, 0);
        check("strobe_merge", model_read(32'h8), 32'hFF22FF44);

        write(32'h100, 32'h12345678, 4'hF, 0, 0, 0);
        read(32'h100, 0);

        write(32'hC, 32'hA5A5A5A5, 4'h0, 1, 0, 0);
        read(32'hC, 0);

        // Second pair accepted while B is stalled, but commits only after B drains.
        send_aw_w(32'h10, 32'h01020304, 4'hF, 0, 0);
        send_aw_w(32'h200, 32'h55555555, 4'hF, 0, 0);
        wait_b(5, -1);
        wait_b(0, 1);
        read(32'h10, 5);

        same_edge(32'h4, 32'hCAFEF00D);
        read(32'h4, 0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0)
                write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read(rand_addr(), $urandom_range(0, 3));
        end
        for (int i = 0; i < DEPTH; i++) read(32'(i * 4), 0);

        // Reset while an AW is held and a read response is stalled.
        awvalid = 1'b1; awaddr = 32'h14;
        arvalid = 1'b1; araddr = 32'h4;
        tick();
        awvalid = 1'b0;
        arvalid = 1'b0;
        check("pre_rst_aw_held", 32'(awready), 32'h0);
        check("pre_rst_rvalid", 32'(rvalid), 32'h1);
        areset = 1'b1;
        #1;
        check("mid_rst_bvalid", 32'(bvalid), 32'h0);
        check("mid_rst_rvalid", 32'(rvalid), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_ready", 32'({awready, wready, arready}), 32'h7);
        tick();
        areset = 1'b0;
        model_clear();
        tick();
        for (int i = 0; i < DEPTH; i++) read(32'(i * 4), 0);

        // A lone W after reset must not commit against the discarded AW.
        wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        repeat (3) tick();
        check("no_stale_commit", 32'(bvalid), 32'h0);
        begin
            wr_t w;
            w.addr = 32'h14; w.data = 32'hFFFFFFFF; w.strb = 4'hF;
            pend.push_back(w);
        end
        awvalid = 1'b1; awaddr = 32'h14;
        tick();
        awvalid = 1'b0;
        wait_b(0, 1);
        for (int i = 0; i < DEPTH; i++) read(32'(i * 4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
